// File: rtl/mac_loop_fsm_if.sv
// Control/streamer/engine bundle for mac_loop_fsm.
// slave  : the FSM side (config and status in, launches out).
// master : the regfile/streamer/engine side driving the FSM.
interface mac_loop_fsm_if #(
  parameter int unsigned NB_STREAM = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned ITER_W    = 16
);
  logic                                test_mode_i;
  logic                                clear_i;
  logic                                start_i;
  logic [LEN_W-1:0]                    len_i;
  logic [ITER_W-1:0]                   iter_i;
  logic                                simple_mul_i;
  logic [NB_STREAM-1:0]                stream_en_i;
  logic [NB_STREAM-1:0][ADDR_W-1:0]    base_i;
  logic [NB_STREAM-1:0][ADDR_W-1:0]    stride_i;
  logic [NB_STREAM-1:0]                ready_start_i;
  logic                                acc_done_i;
  logic [NB_STREAM-1:0]                req_start_o;
  logic [NB_STREAM-1:0][ADDR_W-1:0]    addr_o;
  logic [NB_STREAM-1:0][LEN_W-1:0]     trans_size_o;
  logic                                eng_start_o;
  logic                                eng_clear_o;
  logic                                eng_enable_o;
  logic [ITER_W-1:0]                   iter_cnt_o;
  logic                                busy_o;
  logic                                done_o;

  modport slave (
    input  test_mode_i, clear_i, start_i, len_i, iter_i, simple_mul_i,
           stream_en_i, base_i, stride_i, ready_start_i, acc_done_i,
    output req_start_o, addr_o, trans_size_o, eng_start_o, eng_clear_o,
           eng_enable_o, iter_cnt_o, busy_o, done_o
  );

  modport master (
    output test_mode_i, clear_i, start_i, len_i, iter_i, simple_mul_i,
           stream_en_i, base_i, stride_i, ready_start_i, acc_done_i,
    input  req_start_o, addr_o, trans_size_o, eng_start_o, eng_clear_o,
           eng_enable_o, iter_cnt_o, busy_o, done_o
  );
endinterface

// File: rtl/mac_loop_fsm.sv
// Loop control FSM for MAC-class HWPE engines. Sequences NB_STREAM streamer
// channels (last index = sink) and the engine over iter_i outer iterations,
// generating per-iteration base addresses from per-channel offset accumulators.

// Per-channel offset accumulator and address/size generation.
module mac_loop_chan #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LEN_W   = 16,
  parameter bit          IS_SINK = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              init_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              simple_mul_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [LEN_W-1:0]  trans_size_o
);
  logic [ADDR_W-1:0] off_q, off_d;

  // offset restarts with each job and advances one stride per iteration
  always_comb begin
    off_d = off_q;
    if (init_i)      off_d = '0;
    else if (step_i) off_d = off_q + stride_i;
  end

  // offset register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) off_q <= '0;
    else         off_q <= off_d;
  end

  assign addr_o       = base_i + off_q;
  // a MAC reduction writes a single element per iteration; elementwise writes len
  assign trans_size_o = (IS_SINK && !simple_mul_i) ? LEN_W'(1) : len_i;
endmodule

module mac_loop_fsm #(
  parameter int unsigned NB_STREAM = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned ITER_W    = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  mac_loop_fsm_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE, START, WAIT, COMPUTE, UPDATE, TERMINATE
  } state_e;

  state_e              state_q, state_d;
  logic [ITER_W-1:0]   iter_cnt_q, iter_cnt_d;
  logic                start_q, start_d;
  logic [NB_STREAM-1:0] eff_en;
  logic                ready_all;
  logic                launch, done, job_init, step;
  logic                eng_clear, eng_enable;
  logic [NB_STREAM-1:0][ADDR_W-1:0] addr_w;
  logic [NB_STREAM-1:0][LEN_W-1:0]  tsize_w;
  logic                unused_test_mode;

  assign unused_test_mode = bus.test_mode_i;

  // elementwise mode has no second operand stream: drop channel NB_STREAM-2
  always_comb begin
    eff_en = bus.stream_en_i;
    if (bus.simple_mul_i) eff_en[NB_STREAM-2] = 1'b0;
  end

  assign ready_all = &(bus.ready_start_i | ~eff_en);

  // next state, iteration count and engine/streamer controls
  always_comb begin
    state_d    = state_q;
    iter_cnt_d = iter_cnt_q;
    start_d    = bus.start_i & (state_q == IDLE);
    launch     = 1'b0;
    done       = 1'b0;
    job_init   = 1'b0;
    step       = 1'b0;
    eng_clear  = 1'b1;
    eng_enable = 1'b1;
    case (state_q)
      IDLE: begin
        // start pulse is registered once to decouple it from the regfile path
        if (start_q) begin
          job_init   = 1'b1;
          iter_cnt_d = '0;
          state_d    = (bus.iter_i == '0 || bus.len_i == '0) ? TERMINATE : START;
        end
      end
      START: begin
        if (ready_all) begin
          launch  = 1'b1;
          state_d = COMPUTE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        eng_clear  = 1'b0;
        eng_enable = 1'b0;
        if (ready_all) begin
          launch  = 1'b1;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        eng_clear = 1'b0;
        if (bus.acc_done_i) state_d = UPDATE;
      end
      UPDATE: begin
        step       = 1'b1;
        iter_cnt_d = iter_cnt_q + ITER_W'(1);
        state_d    = (iter_cnt_d == bus.iter_i) ? TERMINATE : START;
      end
      TERMINATE: begin
        eng_enable = 1'b0;
        if (ready_all) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (launch) eng_clear = 1'b0;
    // soft clear aborts anything in flight, including the cycle's launch/done
    if (bus.clear_i) begin
      state_d    = IDLE;
      iter_cnt_d = '0;
      start_d    = 1'b0;
      launch     = 1'b0;
      done       = 1'b0;
      step       = 1'b0;
      job_init   = 1'b1;
      eng_clear  = 1'b1;
      eng_enable = 1'b1;
    end
  end

  // state, iteration counter and registered start
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      iter_cnt_q <= '0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      iter_cnt_q <= iter_cnt_d;
      start_q    <= start_d;
    end
  end

  for (genvar k = 0; k < NB_STREAM; k++) begin : g_chan
    mac_loop_chan #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W),
      .IS_SINK(k == NB_STREAM-1)
    ) u_chan (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .init_i      (job_init),
      .step_i      (step),
      .base_i      (bus.base_i[k]),
      .stride_i    (bus.stride_i[k]),
      .len_i       (bus.len_i),
      .simple_mul_i(bus.simple_mul_i),
      .addr_o      (addr_w[k]),
      .trans_size_o(tsize_w[k])
    );
  end

  assign bus.req_start_o  = launch ? eff_en : '0;
  assign bus.eng_start_o  = launch;
  assign bus.eng_clear_o  = eng_clear;
  assign bus.eng_enable_o = eng_enable;
  assign bus.done_o       = done;
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.iter_cnt_o   = iter_cnt_q;
  assign bus.addr_o       = addr_w;
  assign bus.trans_size_o = tsize_w;
endmodule
